// File: rtl/i2s_rx_if.sv
// i2s_rx_if: frame output stream of the I2S receiver.
//   frame_l / frame_r : left / right sample at the head of the receive FIFO
//   frame_valid       : head is valid (FIFO non-empty)
//   frame_ready       : consumer takes the head when frame_valid & frame_ready
// Modports: master = receiver side (drives the samples), slave = consumer side.
interface i2s_rx_if #(
  parameter int SAMPLE_W = 16
);
  logic [SAMPLE_W-1:0] frame_l;
  logic [SAMPLE_W-1:0] frame_r;
  logic                frame_valid;
  logic                frame_ready;

  modport master (
    output frame_l,
    output frame_r,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_l,
    input  frame_r,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver (target). Oversamples the SCLK/LRCLK/SDATA pads in the
// clk domain, deserialises stereo words MSB-first into SAMPLE_W-bit samples
// (longer slots truncated, shorter ones zero-padded in the LSBs) and queues
// {left,right} frames in a FIFO_DEPTH-entry FIFO with a valid/ready output.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   en           receiver enable (low: word assembly idles, FIFO kept)
//   i2s_sclk     bit clock pad input (asynchronous)
//   i2s_lrclk    word select pad input (asynchronous)
//   i2s_sdata    serial data pad input (asynchronous)
//   frm          i2s_rx_if.master: frame_l, frame_r, frame_valid, frame_ready
//   overrun      sticky flag: a frame was dropped because the FIFO was full
//   overrun_clr  single-cycle clear of overrun (a new drop wins)
//   fmt_lj       left-justified format select, only when I2S_RX_LJ_EN is
//                defined; must only change while en=0
//
// Build option: define I2S_RX_LJ_EN to add fmt_lj and left-justified support.
module i2s_rx #(
  parameter int SAMPLE_W    = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  logic     i2s_sclk,
  input  logic     i2s_lrclk,
  input  logic     i2s_sdata,
  i2s_rx_if.master frm,
  output logic     overrun,
  input  logic     overrun_clr
`ifdef I2S_RX_LJ_EN
  ,
  input  logic     fmt_lj
`endif
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  // ---------------------------------------------------------------- pad sync
  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] lr_sync_reg;
  logic [SYNC_STAGES-1:0] sd_sync_reg;
  logic                   sclk_prev_reg;
  logic                   lr_prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_reg <= '0;
      lr_sync_reg   <= '0;
      sd_sync_reg   <= '0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], i2s_sclk};
      lr_sync_reg   <= {lr_sync_reg[SYNC_STAGES-2:0], i2s_lrclk};
      sd_sync_reg   <= {sd_sync_reg[SYNC_STAGES-2:0], i2s_sdata};
    end
  end

  logic sclk_s, lr_s, sd_s;
  assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
  assign lr_s   = lr_sync_reg[SYNC_STAGES-1];
  assign sd_s   = sd_sync_reg[SYNC_STAGES-1];

  logic sclk_rise, lr_change;
  assign sclk_rise = sclk_s & ~sclk_prev_reg;
  // Compared against the lrclk seen at the previous SCLK rise, not the previous clk.
  assign lr_change = (lr_s != lr_prev_reg);

  // lrclk level that marks the left channel: 0 for I2S, 1 for left-justified.
  logic left_level;
`ifdef I2S_RX_LJ_EN
  assign left_level = fmt_lj;
`else
  assign left_level = 1'b0;
`endif

  logic sync_start;
  assign sync_start = sclk_rise & lr_change & (lr_s == left_level);

  // ------------------------------------------------------- word assembly FSM
  state_t              state_reg, state_next;
  logic [SAMPLE_W-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [SAMPLE_W-1:0] left_reg, left_next;
  logic                push_reg, push_next;
  logic [SAMPLE_W-1:0] push_l_reg, push_l_next;
  logic [SAMPLE_W-1:0] push_r_reg, push_r_next;

  logic                bit_room;
  logic [SAMPLE_W-1:0] shift_ins;   // shift_reg with the current bit placed
  logic [SAMPLE_W-1:0] msb_word;    // fresh word holding only the current bit
  logic [SAMPLE_W-1:0] word;        // word being finalised

  assign bit_room = (cnt_reg < CNT_W'(SAMPLE_W));

  // Bits are written straight into their left-aligned position, so a short
  // word is already zero-padded when it is finalised.
  always_comb begin
    shift_ins = shift_reg;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (bit_room && (cnt_reg == CNT_W'(SAMPLE_W - 1 - i)))
        shift_ins[i] = sd_s;
    end
    msb_word = '0;
    msb_word[SAMPLE_W-1] = sd_s;
  end

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    cnt_next    = cnt_reg;
    left_next   = left_reg;
    push_next   = 1'b0;
    push_l_next = push_l_reg;
    push_r_next = push_r_reg;
    word        = shift_reg;

    case (state_reg)
      IDLE: begin
        shift_next = '0;
        cnt_next   = '0;
        left_next  = '0;
        if (en)
          state_next = SYNC;
      end

      SYNC: begin
        if (sync_start) begin
          state_next = RUN;
          if (left_level) begin
            // Left-justified: this rise already carries the left MSB.
            shift_next = msb_word;
            cnt_next   = CNT_W'(1);
          end else begin
            shift_next = '0;
            cnt_next   = '0;
          end
        end
      end

      RUN: begin
        if (sclk_rise) begin
          if (!lr_change) begin
            shift_next = shift_ins;
            if (bit_room)
              cnt_next = cnt_reg + CNT_W'(1);
          end else begin
            if (left_level) begin
              // The bit belongs to the new word.
              word       = shift_reg;
              shift_next = msb_word;
              cnt_next   = CNT_W'(1);
            end else begin
              // The bit is the LSB of the word that is ending.
              word       = shift_ins;
              shift_next = '0;
              cnt_next   = '0;
            end
            if (lr_prev_reg == left_level) begin
              left_next = word;
            end else begin
              push_next   = 1'b1;
              push_l_next = left_reg;
              push_r_next = word;
            end
          end
        end
      end

      default: state_next = IDLE;
    endcase

    if (!en) begin
      state_next = IDLE;
      push_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      left_reg      <= '0;
      push_reg      <= 1'b0;
      push_l_reg    <= '0;
      push_r_reg    <= '0;
      sclk_prev_reg <= 1'b0;
      lr_prev_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      cnt_reg       <= cnt_next;
      left_reg      <= left_next;
      push_reg      <= push_next;
      push_l_reg    <= push_l_next;
      push_r_reg    <= push_r_next;
      sclk_prev_reg <= sclk_s;
      if (sclk_rise)
        lr_prev_reg <= lr_s;
    end
  end

  // -------------------------------------------------------------------- FIFO
  logic [2*SAMPLE_W-1:0] mem_reg [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]           count_reg;
  logic                  overrun_reg;

  logic full, empty, do_pop, do_push, drop;
  assign full    = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = ~empty & frm.frame_ready;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push = push_reg & (~full | do_pop);
  assign drop    = push_reg & full & ~do_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_reg[i] <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= {push_l_reg, push_r_reg};
        wr_ptr_reg          <= wr_ptr_reg + AW'(1);
      end
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
      overrun_reg <= (overrun_reg & ~overrun_clr) | drop;
    end
  end

  logic [2*SAMPLE_W-1:0] head;
  assign head            = mem_reg[rd_ptr_reg];
  assign frm.frame_l     = head[2*SAMPLE_W-1:SAMPLE_W];
  assign frm.frame_r     = head[SAMPLE_W-1:0];
  assign frm.frame_valid = ~empty;
  assign overrun         = overrun_reg;

endmodule
